axis_fir_coef_sched: RTL and testbench

//   Sample-rate scheduler and coefficient manager for the 9-tap AXIS FIR filters.
//   - Generates the periodic one-cycle input-valid strobe for the filter.
//   - Holds a shadow coefficient bank written over a simple register port.
//   - Commits all taps to the active bank in one clock edge, aligned to a strobe.
//   - The filter therefore never processes a sample with a mix of old and new taps.

---
 rtl/axis_fir_coef_sched.sv | 92 +++++++++
 tb/tb_axis_fir_coef_sched.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/axis_fir_coef_sched.sv
// Strobe generator and double-buffered coefficient bank for the 9-tap FIR.
// New taps reach the active bank in one edge, aligned to a strobe.
module axis_fir_coef_sched #(
    parameter int N_TAPS     = 9,
    parameter int COEF_WIDTH = 16,
    parameter int DIV_WIDTH  = 20
) (
    input  logic                         aclk,
    input  logic                         resetn,
    input  logic [DIV_WIDTH-1:0]         rate_div,
    output logic                         ce_out,
    input  logic                         cfg_we,
    input  logic [3:0]                   cfg_addr,
    input  logic [COEF_WIDTH-1:0]        cfg_wdata,
    input  logic                         cfg_commit,
    output logic                         cfg_busy,
    output logic                         cfg_err,
    output logic                         commit_done,
    output logic [N_TAPS*COEF_WIDTH-1:0] coef_active
);

    typedef enum logic {
        IDLE,
        PENDING
    } state_t;

    state_t state, state_nxt;

    logic [DIV_WIDTH-1:0] cnt;
    logic [N_TAPS-1:0][COEF_WIDTH-1:0] shadow;
    logic [N_TAPS-1:0][COEF_WIDTH-1:0] active;

    logic rate_on;
    logic wrap;
    logic addr_ok;
    logic wr_ok;
    logic copy;

    assign rate_on = |rate_div;
    assign wrap    = cnt >= (rate_div - DIV_WIDTH'(1));
    assign ce_out  = rate_on && wrap;

    assign addr_ok = int'(cfg_addr) < N_TAPS;
    assign wr_ok   = cfg_we && addr_ok && (state == IDLE);

    assign cfg_busy    = (state == PENDING);
    assign coef_active = active;

    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            cnt <= '0;
        end else if (!rate_on || wrap) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + DIV_WIDTH'(1);
        end
    end

    // With the strobe off the copy cannot wait for a strobe, so it goes at once
    always_comb begin
        state_nxt = state;
        copy      = 1'b0;
        unique case (state)
            IDLE: begin
                if (cfg_commit) state_nxt = PENDING;
            end
            PENDING: begin
                if (!rate_on || ce_out) begin
                    copy      = 1'b1;
                    state_nxt = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            shadow      <= '0;
            active      <= '0;
            cfg_err     <= 1'b0;
            commit_done <= 1'b0;
        end else begin
            state       <= state_nxt;
            cfg_err     <= cfg_we && !wr_ok;
            commit_done <= copy;
            if (wr_ok) shadow[cfg_addr] <= cfg_wdata;
            if (copy) active <= shadow;
        end
    end

endmodule

// File: tb/tb_axis_fir_coef_sched.sv
// Directed bench for axis_fir_coef_sched: strobe timing, commit alignment,
// write rejection and reset abandonment.
module tb_axis_fir_coef_sched;

    logic         aclk;
    logic         resetn;
    logic [19:0]  rate_div;
    logic         ce_out;
    logic         cfg_we;
    logic [3:0]   cfg_addr;
    logic [15:0]  cfg_wdata;
    logic         cfg_commit;
    logic         cfg_busy;
    logic         cfg_err;
    logic         commit_done;
    logic [143:0] coef_active;

    axis_fir_coef_sched dut (
        .aclk        (aclk),
        .resetn      (resetn),
        .rate_div    (rate_div),
        .ce_out      (ce_out),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_wdata   (cfg_wdata),
        .cfg_commit  (cfg_commit),
        .cfg_busy    (cfg_busy),
        .cfg_err     (cfg_err),
        .commit_done (commit_done),
        .coef_active (coef_active)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    typedef struct {
        logic        we;
        logic [3:0]  addr;
        logic [15:0] wdata;
        logic        commit;
        logic        busy;
        logic        err;
        logic        done;
        logic [15:0] b0;
        logic [15:0] b8;
    } vec_t;

    vec_t vt[12];

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    logic signed [15:0] taps[9];
    logic [143:0] bank_a;
    logic [143:0] bank_b;

    task automatic chk(input string name, input logic [143:0] act,
                       input logic [143:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            if (fails <= 25)
                $display("FAIL %s cyc=%0d got=%h want=%h",
                         name, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
        cyc++;
    endtask

    task automatic idle_in();
        cfg_we     = 1'b0;
        cfg_addr   = 4'd0;
        cfg_wdata  = 16'd0;
        cfg_commit = 1'b0;
    endtask

    task automatic do_reset(input logic [19:0] rd);
        resetn   = 1'b0;
        rate_div = rd;
        idle_in();
        repeat (2) @(posedge aclk);
        #1;
        resetn = 1'b1;
        cyc    = 0;
    endtask

    initial begin
        taps = '{-16'sd202, -16'sd446, 16'sd1678, 16'sd8705, 16'sd13292,
                 16'sd8705, 16'sd1678, -16'sd446, -16'sd202};
        for (int i = 0; i < 9; i++) bank_a[i*16 +: 16] = taps[i];
        bank_b = bank_a;
        bank_b[3*16 +: 16] = 16'd1111;

        vt[0]  = '{1'b1, 4'd0,  16'd1000,  1'b0, 1'b0, 1'b0, 1'b0, 16'd0,    16'd0};
        vt[1]  = '{1'b0, 4'd0,  16'd0,     1'b1, 1'b1, 1'b0, 1'b0, 16'd0,    16'd0};
        vt[2]  = '{1'b0, 4'd0,  16'd0,     1'b0, 1'b0, 1'b0, 1'b1, 16'd1000, 16'd0};
        vt[3]  = '{1'b0, 4'd0,  16'd0,     1'b0, 1'b0, 1'b0, 1'b0, 16'd1000, 16'd0};
        vt[4]  = '{1'b1, 4'd12, 16'd9,     1'b0, 1'b0, 1'b1, 1'b0, 16'd1000, 16'd0};
        vt[5]  = '{1'b0, 4'd0,  16'd0,     1'b0, 1'b0, 1'b0, 1'b0, 16'd1000, 16'd0};
        vt[6]  = '{1'b1, 4'd8,  16'hFFFB,  1'b1, 1'b1, 1'b0, 1'b0, 16'd1000, 16'd0};
        vt[7]  = '{1'b1, 4'd0,  16'd55,    1'b0, 1'b0, 1'b1, 1'b1, 16'd1000, 16'hFFFB};
        vt[8]  = '{1'b0, 4'd0,  16'd0,     1'b0, 1'b0, 1'b0, 1'b0, 16'd1000, 16'hFFFB};
        vt[9]  = '{1'b0, 4'd0,  16'd0,     1'b1, 1'b1, 1'b0, 1'b0, 16'd1000, 16'hFFFB};
        vt[10] = '{1'b0, 4'd0,  16'd0,     1'b1, 1'b0, 1'b0, 1'b1, 16'd1000, 16'hFFFB};
        vt[11] = '{1'b0, 4'd0,  16'd0,     1'b0, 1'b0, 1'b0, 1'b0, 16'd1000, 16'hFFFB};

        // reset state
        resetn   = 1'b0;
        rate_div = 20'd1000;
        idle_in();
        repeat (3) @(posedge aclk);
        #1;
        chk("rst_ce",     144'(ce_out),      144'd0);
        chk("rst_busy",   144'(cfg_busy),    144'd0);
        chk("rst_err",    144'(cfg_err),     144'd0);
        chk("rst_done",   144'(commit_done), 144'd0);
        chk("rst_active", coef_active,       144'd0);

        // strobe period, aligned commit, rejected writes
        resetn = 1'b1;
        cyc    = 0;
        for (int c = 0; c <= 3000; c++) begin
            chk("t12_ce", 144'(ce_out),
                144'(c == 999 || c == 1999 || c == 2999));
            chk("t12_busy", 144'(cfg_busy),
                144'((c >= 11 && c <= 999) || (c >= 1031 && c <= 1999)));
            chk("t12_done", 144'(commit_done), 144'(c == 1000 || c == 2000));
            chk("t12_err", 144'(cfg_err), 144'(c == 1011 || c == 1041));
            chk("t12_active", coef_active,
                (c < 1000) ? 144'd0 : (c < 2000) ? bank_a : bank_b);
            idle_in();
            if (c <= 8) begin
                cfg_we    = 1'b1;
                cfg_addr  = 4'(c);
                cfg_wdata = taps[c];
            end
            if (c == 10 || c == 1030) cfg_commit = 1'b1;
            if (c == 1010) begin
                cfg_we = 1'b1; cfg_addr = 4'd9; cfg_wdata = 16'h7FFF;
            end
            if (c == 1020) begin
                cfg_we = 1'b1; cfg_addr = 4'd3; cfg_wdata = 16'd1111;
            end
            if (c == 1040) begin
                cfg_we = 1'b1; cfg_addr = 4'd3; cfg_wdata = 16'd7777;
            end
            tick();
        end

        // strobe off: table of single-cycle vectors
        do_reset(20'd0);
        for (int i = 0; i < 12; i++) begin
            cfg_we     = vt[i].we;
            cfg_addr   = vt[i].addr;
            cfg_wdata  = vt[i].wdata;
            cfg_commit = vt[i].commit;
            tick();
            chk($sformatf("v%0d_busy", i), 144'(cfg_busy),    144'(vt[i].busy));
            chk($sformatf("v%0d_err", i),  144'(cfg_err),     144'(vt[i].err));
            chk($sformatf("v%0d_done", i), 144'(commit_done), 144'(vt[i].done));
            chk($sformatf("v%0d_ce", i),   144'(ce_out),      144'd0);
            chk($sformatf("v%0d_b0", i),   144'(coef_active[15:0]),    144'(vt[i].b0));
            chk($sformatf("v%0d_b8", i),   144'(coef_active[143:128]), 144'(vt[i].b8));
        end
        idle_in();

        // reset while a commit is pending
        rate_div = 20'd1000;
        resetn   = 1'b0;
        #1;
        chk("t6_pre_active", coef_active, 144'd0);
        @(posedge aclk);
        #1;
        resetn = 1'b1;
        cyc    = 0;
        for (int c = 0; c < 500; c++) begin
            idle_in();
            if (c == 3) begin
                cfg_we = 1'b1; cfg_addr = 4'd0; cfg_wdata = 16'd42;
            end
            if (c == 5) cfg_commit = 1'b1;
            tick();
        end
        idle_in();
        chk("t6_busy_before", 144'(cfg_busy), 144'd1);
        #2;
        resetn = 1'b0;
        #1;
        chk("t6_ce",     144'(ce_out),      144'd0);
        chk("t6_busy",   144'(cfg_busy),    144'd0);
        chk("t6_err",    144'(cfg_err),     144'd0);
        chk("t6_done",   144'(commit_done), 144'd0);
        chk("t6_active", coef_active,       144'd0);
        @(posedge aclk);
        #1;
        resetn = 1'b1;
        cyc    = 0;
        for (int c = 0; c <= 1200; c++) begin
            chk("t6r_ce",     144'(ce_out),      144'(c == 999));
            chk("t6r_busy",   144'(cfg_busy),    144'd0);
            chk("t6r_done",   144'(commit_done), 144'd0);
            chk("t6r_active", coef_active,       144'd0);
            tick();
        end

        // shadow must have been cleared by reset as well
        cfg_commit = 1'b1;
        tick();
        idle_in();
        for (int c = 0; c < 1100 && !commit_done; c++) tick();
        chk("t6_commit_done", 144'(commit_done), 144'd1);
        chk("t6_shadow_clr",  coef_active,       144'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
